// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding,
// byte width and default stall timeout.
package uart_pkg;

   localparam int unsigned BYTE_W      = 8;
   localparam int unsigned TMO_DEFAULT = 65535;
   localparam int unsigned CNT_W       = 17;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      BUSY
   } state_t;

endpackage

// File: rtl/uart_arb_if.sv
// Per-port transmit request bundle: valid/data/last offered by the
// requesters, ready returned by the arbiter.
interface uart_arb_if #(
   parameter int unsigned N = 4
);
   import uart_pkg::*;

   logic [N-1:0]          req_valid;
   logic [BYTE_W*N-1:0]   req_data;
   logic [N-1:0]          req_last;
   logic [N-1:0]          req_ready;

   modport master (
      output req_valid, req_data, req_last,
      input  req_ready
   );

   modport slave (
      input  req_valid, req_data, req_last,
      output req_ready
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request searching upward from start+1,
// wrapping at N-1; grant is one-hot, idx its position.
module rr_pick #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   start,
   input  logic         en,
   output logic [N-1:0] grant,
   output logic [2:0]   idx,
   output logic         any
);

   always_comb begin
      int unsigned  p;
      logic [N-1:0] cand;
      grant = '0;
      idx   = start;
      any   = 1'b0;
      p     = 0;
      cand  = '0;
      // k = N wraps back to start itself, which the locked case relies on
      for (int unsigned k = 1; k <= N; k++) begin
         p    = (32'(start) + k) % N;
         cand = N'(1) << p;
         if (en && !any && ((req & cand) != '0)) begin
            grant = cand;
            idx   = 3'(p);
            any   = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_arb.sv
// Arbitrates N byte requesters onto one UART transmitter with packet
// locking, and fans received bytes out to the enabled ports.
module uart_arb
   import uart_pkg::*;
#(
   parameter int unsigned N   = 4,
   parameter int unsigned TMO = TMO_DEFAULT
) (
   input  logic              clk,
   input  logic              nreset,
   uart_arb_if.slave         req,
   input  logic [N-1:0]      rx_en,
   output logic [N-1:0]      rx_valid,
   output logic [BYTE_W-1:0] rx_data,
   output logic [BYTE_W-1:0] od,
   output logic              dox,
   input  logic              wip,
   input  logic [BYTE_W-1:0] id,
   input  logic              dix,
   output logic [2:0]        owner,
   output logic              locked,
   output logic              stall
);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [N-1:0]       elig;
   logic [N-1:0]       grant;
   logic [2:0]         pick_idx;
   logic               pick_any;
   logic [BYTE_W-1:0]  sel_data;
   logic               sel_last;

   // While a packet is locked only the owner may be offered to the picker
   assign elig = locked ? (req.req_valid & (N'(1) << owner)) : req.req_valid;

   rr_pick #(.N(N)) u_pick (
      .req   (elig),
      .start (owner),
      .en    ((state == IDLE) && !wip),
      .grant (grant),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   always_comb begin
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (grant[i]) begin
            sel_data = req.req_data[BYTE_W*i +: BYTE_W];
            sel_last = req.req_last[i];
         end
      end
   end

   assign req.req_ready = grant;
   assign dox           = (state == SEND);
   assign stall         = (state == SEND) && (cnt >= CNT_W'(TMO));

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state    <= IDLE;
         od       <= '0;
         owner    <= 3'(N-1);
         locked   <= 1'b0;
         cnt      <= '0;
         rx_valid <= '0;
         rx_data  <= '0;
      end else begin
         rx_valid <= dix ? rx_en : '0;
         if (dix) rx_data <= id;
         unique case (state)
            IDLE: begin
               if (pick_any) begin
                  od     <= sel_data;
                  owner  <= pick_idx;
                  locked <= !sel_last;
                  // first SEND cycle already counts as one
                  cnt    <= CNT_W'(1);
                  state  <= SEND;
               end
            end
            SEND: begin
               if (wip) begin
                  state <= BUSY;
                  cnt   <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            BUSY: begin
               if (!wip) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_arb.sv
// Self-checking bench for uart_arb: directed scenarios plus a randomized
// run scored against a round-robin/lock reference model.
module tb_uart_arb;

   localparam int N   = 4;
   localparam int TMO = 10;

   logic         clk = 1'b0;
   logic         nreset = 1'b0;
   logic [N-1:0] rx_en = '0;
   logic [N-1:0] rx_valid;
   logic [7:0]   rx_data;
   logic [7:0]   od;
   logic         dox;
   logic         wip = 1'b0;
   logic [7:0]   id = '0;
   logic         dix = 1'b0;
   logic [2:0]   owner;
   logic         locked;
   logic         stall;

   uart_arb_if #(.N(N)) bus_if ();

   uart_arb #(.N(N), .TMO(TMO)) dut (
      .clk      (clk),
      .nreset   (nreset),
      .req      (bus_if),
      .rx_en    (rx_en),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .od       (od),
      .dox      (dox),
      .wip      (wip),
      .id       (id),
      .dix      (dix),
      .owner    (owner),
      .locked   (locked),
      .stall    (stall)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // UART transmitter model: in auto mode it answers dox by raising wip
   // for frame_len cycles; otherwise wip follows wip_man.
   bit   uart_auto = 1'b0;
   logic wip_man   = 1'b0;
   int   frame_len = 20;
   int   busy_left = 0;

   always @(negedge clk) begin
      if (!uart_auto) begin
         wip = wip_man;
         busy_left = 0;
      end else if (busy_left > 0) begin
         busy_left--;
         if (busy_left == 0) wip = 1'b0;
      end else if (dox) begin
         wip = 1'b1;
         busy_left = frame_len;
      end else begin
         wip = 1'b0;
      end
   end

   logic       vld [N];
   logic       lst [N];
   logic [7:0] dat [N];

   task automatic drive();
      for (int p = 0; p < N; p++) begin
         bus_if.req_valid[p]      = vld[p];
         bus_if.req_last[p]       = lst[p];
         bus_if.req_data[8*p +: 8] = dat[p];
      end
   endtask

   task automatic clear_inputs();
      for (int p = 0; p < N; p++) begin
         vld[p] = 1'b0;
         lst[p] = 1'b0;
         dat[p] = 8'h00;
      end
      drive();
      dix = 1'b0;
      id = 8'h00;
      rx_en = '0;
   endtask

   // Called at posedge+1; samples the acceptance just before the next edge.
   task automatic tick(output logic [N-1:0] acc);
      @(negedge clk);
      #1;
      acc = bus_if.req_valid & bus_if.req_ready;
      @(posedge clk);
      #1;
   endtask

   // -1: no bit set, -2: more than one bit set
   function automatic int idx_of(logic [N-1:0] m);
      int r = -1;
      for (int i = 0; i < N; i++)
         if (m[i]) r = (r == -1) ? i : -2;
      return r;
   endfunction

   // Reference arbitration rule: locked -> owner only; else next valid after owner.
   function automatic int model_pick(logic [N-1:0] v, int own, bit lk);
      for (int k = 1; k <= N; k++) begin
         int p = (own + k) % N;
         if (v[p] && (!lk || p == own)) return p;
      end
      return -1;
   endfunction

   task automatic do_reset();
      nreset = 1'b0;
      uart_auto = 1'b0;
      wip_man = 1'b0;
      clear_inputs();
      repeat (3) @(posedge clk);
      #1;
      nreset = 1'b1;
   endtask

   task automatic test_reset();
      logic [22:0] want;
      want = {8'h00, 1'b0, 3'(N-1), 1'b0, 1'b0, 4'b0000, 8'h00};
      nreset = 1'b0;
      uart_auto = 1'b0;
      wip_man = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({od, dox, owner, locked, stall, rx_valid, rx_data} !== want) begin
         bad++;
         $display("FAIL reset_hold got=%h want=%h", {od, dox, owner, locked, stall, rx_valid, rx_data}, want);
      end
      nreset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({od, dox, owner, locked, stall, rx_valid, rx_data} !== want || bus_if.req_ready !== '0) begin
         bad++;
         $display("FAIL reset_release got=%h ready=%b want=%h ready=0", {od, dox, owner, locked, stall, rx_valid, rx_data}, bus_if.req_ready, want);
      end
   endtask

   task automatic test_two_ports();
      logic [N-1:0] acc;
      int order[$];
      logic [7:0] bytes[$];
      int widths[$];
      int run = 0;
      int g;
      do_reset();
      frame_len = 20;
      uart_auto = 1'b1;
      vld[0] = 1'b1; dat[0] = 8'h41; lst[0] = 1'b1;
      vld[2] = 1'b1; dat[2] = 8'h43; lst[2] = 1'b1;
      drive();
      for (int c = 0; c < 100; c++) begin
         tick(acc);
         g = idx_of(acc);
         if (g != -1) begin
            order.push_back(g);
            bytes.push_back(od);
            if (g >= 0) begin
               vld[g] = 1'b0;
               drive();
            end
         end
         if (dox) run++;
         else if (run > 0) begin
            widths.push_back(run);
            run = 0;
         end
      end
      total++;
      if (order.size() != 2) begin
         bad++;
         $display("FAIL two_ports_count got=%0d want=2", order.size());
      end else begin
         total++;
         if (order[0] !== 0 || bytes[0] !== 8'h41) begin
            bad++;
            $display("FAIL two_ports_first got=port%0d od=%h want=port0 od=41", order[0], bytes[0]);
         end
         total++;
         if (order[1] !== 2 || bytes[1] !== 8'h43) begin
            bad++;
            $display("FAIL two_ports_second got=port%0d od=%h want=port2 od=43", order[1], bytes[1]);
         end
      end
      total++;
      if (widths.size() != 2) begin
         bad++;
         $display("FAIL two_ports_dox_pulses got=%0d want=2", widths.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            total++;
            if (widths[i] != 1) begin
               bad++;
               $display("FAIL two_ports_dox_width%0d got=%0d want=1", i, widths[i]);
            end
         end
      end
   endtask

   task automatic test_packet();
      logic [N-1:0] acc;
      logic [7:0] b[3];
      int order[$];
      logic [7:0] ob[$];
      logic lk[$];
      int exp_g[4];
      logic [7:0] exp_d[4];
      logic exp_l[4];
      int nb = 0;
      int g;
      do_reset();
      frame_len = 4;
      uart_auto = 1'b1;
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
      vld[1] = 1'b1; dat[1] = b[0]; lst[1] = 1'b0;
      vld[3] = 1'b1; dat[3] = 8'h33; lst[3] = 1'b1;
      drive();
      exp_g = '{1, 1, 1, 3};
      exp_d = '{b[0], b[1], b[2], 8'h33};
      exp_l = '{1'b1, 1'b1, 1'b0, 1'b0};
      for (int c = 0; c < 200 && order.size() < 4; c++) begin
         tick(acc);
         g = idx_of(acc);
         if (g != -1) begin
            order.push_back(g);
            ob.push_back(od);
            lk.push_back(locked);
            if (g == 1) begin
               nb++;
               if (nb < 3) begin
                  dat[1] = b[nb];
                  lst[1] = (nb == 2);
               end else begin
                  vld[1] = 1'b0;
               end
               drive();
            end
         end
      end
      total++;
      if (order.size() != 4) begin
         bad++;
         $display("FAIL packet_count got=%0d want=4", order.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (order[i] !== exp_g[i] || ob[i] !== exp_d[i] || lk[i] !== exp_l[i]) begin
               bad++;
               $display("FAIL packet_grant%0d got=port%0d od=%h locked=%b want=port%0d od=%h locked=%b",
                        i, order[i], ob[i], lk[i], exp_g[i], exp_d[i], exp_l[i]);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [N-1:0] acc;
      do_reset();
      vld[0] = 1'b1; dat[0] = 8'h99; lst[0] = 1'b1;
      drive();
      tick(acc);
      total++;
      if (acc !== 4'b0001 || od !== 8'h99) begin
         bad++;
         $display("FAIL stall_accept got=acc%b od=%h want=acc0001 od=99", acc, od);
      end
      vld[0] = 1'b0;
      drive();
      for (int k = 1; k <= 14; k++) begin
         total++;
         if (dox !== 1'b1 || stall !== (k >= TMO)) begin
            bad++;
            $display("FAIL stall_send%0d got=dox%b stall%b want=dox1 stall%b", k, dox, stall, k >= TMO);
         end
         if (k < 14) tick(acc);
      end
      wip_man = 1'b1;
      tick(acc);
      total++;
      if (dox !== 1'b0 || stall !== 1'b0) begin
         bad++;
         $display("FAIL stall_busy got=dox%b stall%b want=dox0 stall0", dox, stall);
      end
      wip_man = 1'b0;
      tick(acc);
   endtask

   task automatic test_rx();
      logic [N-1:0] acc;
      logic         pd;
      logic [7:0]   pid;
      logic [7:0]   held;
      logic [N-1:0] pen;
      logic [N-1:0] ev;
      do_reset();
      vld[0] = 1'b1; dat[0] = 8'h11; lst[0] = 1'b1;
      drive();
      tick(acc);
      vld[0] = 1'b0;
      drive();
      wip_man = 1'b1;
      tick(acc);
      dix = 1'b1; id = 8'h5A; rx_en = 4'b1010;
      tick(acc);
      dix = 1'b0; id = 8'h00;
      total++;
      if (rx_valid !== 4'b1010 || rx_data !== 8'h5A || dox !== 1'b0) begin
         bad++;
         $display("FAIL rx_busy got=%b/%h want=1010/5a", rx_valid, rx_data);
      end
      tick(acc);
      total++;
      if (rx_valid !== 4'b0000 || rx_data !== 8'h5A) begin
         bad++;
         $display("FAIL rx_after got=%b/%h want=0000/5a", rx_valid, rx_data);
      end
      held = 8'h5A;
      for (int i = 0; i < 24; i++) begin
         if (i == 12) wip_man = 1'b0;
         pd  = ($urandom_range(0, 2) != 0);
         pid = 8'($urandom);
         pen = N'($urandom);
         dix = pd; id = pid; rx_en = pen;
         tick(acc);
         ev = pd ? pen : '0;
         if (pd) held = pid;
         total++;
         if (rx_valid !== ev || rx_data !== held) begin
            bad++;
            $display("FAIL rx_rand%0d got=%b/%h want=%b/%h", i, rx_valid, rx_data, ev, held);
         end
      end
      dix = 1'b0;
      rx_en = '0;
   endtask

   task automatic test_reset_busy();
      logic [N-1:0] acc;
      logic [22:0] want;
      want = {8'h00, 1'b0, 3'(N-1), 1'b0, 1'b0, 4'b0000, 8'h00};
      do_reset();
      vld[0] = 1'b1; dat[0] = 8'h77; lst[0] = 1'b1;
      drive();
      tick(acc);
      total++;
      if (acc !== 4'b0001) begin
         bad++;
         $display("FAIL rbusy_accept got=%b want=0001", acc);
      end
      wip_man = 1'b1;
      dix = 1'b1; id = 8'hC3; rx_en = '1;
      tick(acc);
      dix = 1'b0;
      total++;
      if (dox !== 1'b0 || rx_data !== 8'hC3) begin
         bad++;
         $display("FAIL rbusy_state got=dox%b rx%h want=dox0 rxc3", dox, rx_data);
      end
      #2;
      nreset = 1'b0;
      #1;
      total++;
      if ({od, dox, owner, locked, stall, rx_valid, rx_data} !== want || bus_if.req_ready !== '0) begin
         bad++;
         $display("FAIL rbusy_async got=%h ready=%b want=%h ready=0", {od, dox, owner, locked, stall, rx_valid, rx_data}, bus_if.req_ready, want);
      end
      wip_man = 1'b0;
      @(negedge clk);
      #1;
      nreset = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (owner !== 3'd0 || od !== 8'h77 || dox !== 1'b1 || locked !== 1'b0) begin
         bad++;
         $display("FAIL rbusy_regrant got=owner%0d od%h dox%b lk%b want=owner0 od77 dox1 lk0", owner, od, dox, locked);
      end
      vld[0] = 1'b0;
      drive();
   endtask

   task automatic test_fair();
      logic [N-1:0] acc;
      int order[$];
      int g;
      do_reset();
      frame_len = 3;
      uart_auto = 1'b1;
      for (int p = 0; p < N; p++) begin
         vld[p] = 1'b1; lst[p] = 1'b1; dat[p] = 8'(8'h10 + p);
      end
      drive();
      for (int c = 0; c < 200 && order.size() < 5; c++) begin
         tick(acc);
         g = idx_of(acc);
         if (g != -1) order.push_back(g);
      end
      total++;
      if (order.size() != 5) begin
         bad++;
         $display("FAIL fair_count got=%0d want=5", order.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (order[i] != i % N) begin
               bad++;
               $display("FAIL fair_grant%0d got=%0d want=%0d", i, order[i], i % N);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [N-1:0] acc;
      logic [N-1:0] snap;
      int mo = N - 1;
      bit ml = 1'b0;
      int g, e, p;
      int grants = 0;
      int wait_c = 0;
      do_reset();
      uart_auto = 1'b1;
      for (int q = 0; q < N; q++) begin
         vld[q] = 1'($urandom);
         dat[q] = 8'($urandom);
         lst[q] = 1'($urandom);
      end
      drive();
      for (int c = 0; c < 4000 && grants < 40; c++) begin
         frame_len = $urandom_range(1, 8);
         for (int q = 0; q < N; q++) snap[q] = vld[q];
         tick(acc);
         if (acc != '0) begin
            g = idx_of(acc);
            e = model_pick(snap, mo, ml);
            grants++;
            wait_c = 0;
            total++;
            if (g !== e) begin
               bad++;
               $display("FAIL rand_grant%0d got=%0d want=%0d", grants, g, e);
            end
            if (e >= 0) begin
               total++;
               if (od !== dat[e] || owner !== 3'(e) || locked !== !lst[e] || dox !== 1'b1) begin
                  bad++;
                  $display("FAIL rand_accept%0d got=od%h own%0d lk%b dox%b want=od%h own%0d lk%b dox1",
                           grants, od, owner, locked, dox, dat[e], e, !lst[e]);
               end
               mo = e;
               ml = !lst[e];
               dat[e] = 8'($urandom);
               lst[e] = 1'($urandom);
               vld[e] = ($urandom_range(0, 3) != 0);
            end
         end else begin
            if (model_pick(snap, mo, ml) >= 0) wait_c++;
            else wait_c = 0;
            if (wait_c > 40) begin
               total++;
               bad++;
               $display("FAIL rand_stuck got=no_grant_%0d_cycles want=grant", wait_c);
               break;
            end
         end
         if ($urandom_range(0, 4) == 0) begin
            p = $urandom_range(0, N - 1);
            vld[p] = !vld[p];
         end
         drive();
      end
      total++;
      if (grants < 40) begin
         bad++;
         $display("FAIL rand_progress got=%0d want=40", grants);
      end
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_two_ports();
      test_packet();
      test_stall();
      test_rx();
      test_reset_busy();
      test_fair();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
